// File: rtl/ps2_matrix_pkg.sv
// ps2_matrix_pkg: shared prefix bytes, mapper kind encodings and parser states
package ps2_matrix_pkg;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [1:0] MAP_NONE  = 2'd0;
  localparam logic [1:0] MAP_KEY   = 2'd1;
  localparam logic [1:0] MAP_MOD   = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_LOOKUP, ST_APPLY} pstate_t;
endpackage

// File: rtl/ps2_matrix_engine_parser.sv
// ps2_prefix_parser: E0/F0/E1 prefix decoding and mapper lookup sequencing
module ps2_prefix_parser
  import ps2_matrix_pkg::*;
#(
  parameter int MAP_LAT = 1,
  parameter int E1_SKIP = 7
) (
  input  logic       clkk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic [8:0] map_code,
  output logic       apply,
  output logic       brk
);
  pstate_t    state;
  logic       ext;
  logic [1:0] lat;
  logic [7:0] skip;
  always_ff @(posedge clkk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ext        <= 1'b0;
      brk        <= 1'b0;
      lat        <= '0;
      skip       <= '0;
      map_code   <= '0;
      byte_ready <= 1'b1;
      apply      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (byte_valid) begin
          if (byte_data == PS2_EXT) ext <= 1'b1;
          else if (byte_data == PS2_BRK) brk <= 1'b1;
          else if (byte_data == PS2_PAUSE) begin
            skip  <= 8'(E1_SKIP);
            ext   <= 1'b0;
            brk   <= 1'b0;
            state <= (E1_SKIP == 0) ? ST_IDLE : ST_SKIP;
          end else begin
            map_code   <= {ext, byte_data};
            lat        <= 2'(MAP_LAT - 1);
            byte_ready <= 1'b0;
            state      <= ST_LOOKUP;
          end
        end
        ST_SKIP: if (byte_valid) begin
          skip  <= skip - 8'd1;
          state <= (skip == 8'd1) ? ST_IDLE : ST_SKIP;
        end
        ST_LOOKUP: begin
          lat   <= lat - 2'd1;
          apply <= (lat == 2'd0);
          state <= (lat == 2'd0) ? ST_APPLY : ST_LOOKUP;
        end
        default: begin
          apply      <= 1'b0;
          ext        <= 1'b0;
          brk        <= 1'b0;
          byte_ready <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/ps2_matrix_engine.sv
// ps2_matrix_engine: PS/2 scancode stream to ROWS x COLS key matrix with modifiers,
// key events, pressed-key count, bulk release and stuck-key watchdog
module ps2_matrix_engine
  import ps2_matrix_pkg::*;
#(
  parameter int          ROWS          = 8,
  parameter int          COLS          = 8,
  parameter int          MOD_N         = 8,
  parameter int          MAP_LAT       = 1,
  parameter logic [23:0] STUCK_TIMEOUT = 24'd0,
  parameter int          E1_SKIP       = 7,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int MW = (MOD_N > 1) ? $clog2(MOD_N) : 1,
  localparam int KW = $clog2(ROWS * COLS + 1)
) (
  input  logic             clkk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic [8:0]       map_code,
  input  logic [1:0]       map_kind,
  input  logic [RW-1:0]    map_row,
  input  logic [CW-1:0]    map_col,
  input  logic [MW-1:0]    map_mod,
  input  logic [ROWS-1:0]  rowselect,
  output logic [COLS-1:0]  rowbits,
  output logic [MOD_N-1:0] mods,
  input  logic             all_release,
  output logic             event_valid,
  output logic             event_make,
  output logic [8:0]       event_code,
  output logic [KW-1:0]    keys_down,
  output logic             stuck_release
);
  localparam logic [23:0] WD_LAST = STUCK_TIMEOUT - 24'd1;
  logic [ROWS-1:0][COLS-1:0] mtx;
  logic [COLS-1:0]           row_or;
  logic [23:0]               wd;
  logic apply, brk, key_hit, mod_hit, cur, wd_fire;
  ps2_prefix_parser #(.MAP_LAT(MAP_LAT), .E1_SKIP(E1_SKIP)) u_parser (
    .clkk, .reset, .byte_valid, .byte_data, .byte_ready, .map_code, .apply, .brk
  );
  always_comb begin
    key_hit = apply && map_kind == MAP_KEY && 32'(map_row) < ROWS && 32'(map_col) < COLS;
    mod_hit = apply && map_kind == MAP_MOD && 32'(map_mod) < MOD_N;
    cur     = mtx[map_row][map_col];
    wd_fire = STUCK_TIMEOUT != 24'd0 && wd == WD_LAST && keys_down != '0 && !byte_valid;
    row_or  = '0;
    for (int r = 0; r < ROWS; r++) row_or |= rowselect[r] ? mtx[r] : '0;
  end
  always_ff @(posedge clkk) begin
    if (reset) begin
      mtx           <= '0;
      mods          <= '0;
      rowbits       <= '0;
      keys_down     <= '0;
      event_valid   <= 1'b0;
      event_make    <= 1'b0;
      event_code    <= '0;
      stuck_release <= 1'b0;
      wd            <= '0;
    end else begin
      event_valid   <= key_hit || mod_hit;
      event_make    <= !brk;
      event_code    <= map_code;
      stuck_release <= wd_fire;
      rowbits       <= row_or;
      wd            <= (byte_valid && byte_ready) || keys_down == '0 || wd_fire ? 24'd0 : wd + 24'd1;
      if (all_release) begin
        mtx       <= '0;
        mods      <= '0;
        keys_down <= '0;
      end else begin
        // count only real transitions so typematic repeats and stray breaks leave it alone
        if (wd_fire) begin
          mtx       <= '0;
          keys_down <= '0;
        end else if (key_hit) begin
          mtx[map_row][map_col] <= !brk;
          keys_down <= keys_down + KW'(!brk && !cur) - KW'(brk && cur);
        end
        if (mod_hit) mods[map_mod] <= !brk;
      end
    end
  end
endmodule

// File: tb/tb_ps2_matrix_engine.sv
// tb_ps2_matrix_engine: directed checks of parsing, matrix, modifiers, release and watchdog
module tb_ps2_matrix_engine;
  logic       clkk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready;
  logic [8:0] map_code;
  logic [1:0] map_kind = 2'd0;
  logic [2:0] map_row = 3'd0, map_col = 3'd0, map_mod = 3'd0;
  logic [7:0] rowselect = 8'h00;
  logic [7:0] rowbits, mods;
  logic       all_release = 1'b0;
  logic       event_valid, event_make, stuck_release;
  logic [8:0] event_code;
  logic [6:0] keys_down;
  int total = 0, bad = 0, ev_cnt = 0;
  logic [8:0] last_code = '0;
  logic       last_make = 1'b0;

  ps2_matrix_engine #(.STUCK_TIMEOUT(24'd100)) dut (
    .clkk(clkk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .map_code(map_code), .map_kind(map_kind), .map_row(map_row),
    .map_col(map_col), .map_mod(map_mod), .rowselect(rowselect), .rowbits(rowbits),
    .mods(mods), .all_release(all_release), .event_valid(event_valid),
    .event_make(event_make), .event_code(event_code), .keys_down(keys_down),
    .stuck_release(stuck_release)
  );

  always #5 clkk = ~clkk;

  // external mapper with one cycle of latency
  always @(posedge clkk) begin
    map_kind <= 2'd0; map_row <= 3'd0; map_col <= 3'd0; map_mod <= 3'd0;
    case (map_code)
      9'h01C: begin map_kind <= 2'd1; map_row <= 3'd2; map_col <= 3'd3; end
      9'h175: begin map_kind <= 2'd1; map_row <= 3'd7; map_col <= 3'd0; end
      9'h012: begin map_kind <= 2'd2; map_mod <= 3'd0; end
      default: ;
    endcase
  end

  always begin
    @(posedge clkk);
    #1;
    if (!reset && event_valid) begin
      ev_cnt++;
      last_code = event_code;
      last_make = event_make;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clkk);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clkk);
    while (!byte_ready && n < 50) begin
      @(negedge clkk);
      n++;
    end
    if (n >= 50) chk("ready_wait", 32'(n), 32'd0);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clkk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic pulse_release();
    @(negedge clkk) all_release = 1'b1;
    @(negedge clkk) all_release = 1'b0;
  endtask

  initial begin
    int first, pulses;
    idle(3);
    chk("rst_ready", 32'(byte_ready), 32'd1);
    chk("rst_keys", 32'(keys_down), 32'd0);
    chk("rst_mods", 32'(mods), 32'd0);
    chk("rst_rowbits", 32'(rowbits), 32'd0);
    chk("rst_event", 32'(event_valid), 32'd0);
    chk("rst_stuck", 32'(stuck_release), 32'd0);
    reset = 1'b0;
    // 1: plain make / break
    rowselect = 8'h04;
    send(8'h1C);
    chk("t1_busy", 32'(byte_ready), 32'd0);
    chk("t1_map_code", 32'(map_code), 32'h01C);
    idle(4);
    chk("t1_keys", 32'(keys_down), 32'd1);
    chk("t1_rowbits", 32'(rowbits), 32'h08);
    chk("t1_ev", 32'(ev_cnt), 32'd1);
    chk("t1_make", 32'(last_make), 32'd1);
    rowselect = 8'h00;
    idle(2);
    chk("t1_nosel", 32'(rowbits), 32'h00);
    rowselect = 8'h04;
    send(8'hF0); send(8'h1C);
    idle(4);
    chk("t1_brk_keys", 32'(keys_down), 32'd0);
    chk("t1_brk_rowbits", 32'(rowbits), 32'h00);
    chk("t1_brk_ev", 32'(ev_cnt), 32'd2);
    chk("t1_brk_make", 32'(last_make), 32'd0);
    // 2: extended key, then an unmapped break
    rowselect = 8'h80;
    send(8'hE0); send(8'h75);
    chk("t2_map_code", 32'(map_code), 32'h175);
    idle(4);
    chk("t2_code", 32'(last_code), 32'h175);
    chk("t2_make", 32'(last_make), 32'd1);
    chk("t2_ev", 32'(ev_cnt), 32'd3);
    chk("t2_rowbits", 32'(rowbits), 32'h01);
    send(8'hF0); send(8'h75);
    chk("t2_unmapped_code", 32'(map_code), 32'h075);
    idle(4);
    chk("t2_unmapped_ev", 32'(ev_cnt), 32'd3);
    chk("t2_unmapped_keys", 32'(keys_down), 32'd1);
    chk("t2_unmapped_rowbits", 32'(rowbits), 32'h01);
    pulse_release();
    idle(2);
    chk("t2_release_keys", 32'(keys_down), 32'd0);
    chk("t2_release_rowbits", 32'(rowbits), 32'h00);
    // 3: modifier
    send(8'h12);
    idle(4);
    chk("t3_mod_on", 32'(mods), 32'h01);
    chk("t3_ev_on", 32'(ev_cnt), 32'd4);
    chk("t3_keys", 32'(keys_down), 32'd0);
    send(8'hF0); send(8'h12);
    idle(4);
    chk("t3_mod_off", 32'(mods), 32'h00);
    chk("t3_ev_off", 32'(ev_cnt), 32'd5);
    // 4: pause sequence is swallowed
    rowselect = 8'h04;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(4);
    chk("t4_skip_ev", 32'(ev_cnt), 32'd5);
    chk("t4_skip_keys", 32'(keys_down), 32'd0);
    send(8'h1C);
    idle(4);
    chk("t4_after_ev", 32'(ev_cnt), 32'd6);
    chk("t4_after_make", 32'(last_make), 32'd1);
    chk("t4_after_code", 32'(last_code), 32'h01C);
    chk("t4_after_rowbits", 32'(rowbits), 32'h08);
    // 5: typematic repeats, release colliding with the last apply
    pulse_release();
    idle(2);
    chk("t5_clear", 32'(keys_down), 32'd0);
    send(8'h12);
    idle(4);
    chk("t5_mod", 32'(mods), 32'h01);
    send(8'h1C); send(8'h1C); send(8'h1C);
    idle(4);
    chk("t5_rep_keys", 32'(keys_down), 32'd1);
    chk("t5_rep_ev", 32'(ev_cnt), 32'd10);
    send(8'h1C);
    @(negedge clkk);
    @(negedge clkk) all_release = 1'b1;
    @(negedge clkk) all_release = 1'b0;
    idle(3);
    chk("t5_rel_keys", 32'(keys_down), 32'd0);
    chk("t5_rel_mods", 32'(mods), 32'h00);
    chk("t5_rel_rowbits", 32'(rowbits), 32'h00);
    chk("t5_rel_ev", 32'(ev_cnt), 32'd11);
    // 6: watchdog
    send(8'h12);
    idle(4);
    chk("t6_mod", 32'(mods), 32'h01);
    send(8'h1C);
    first = -1;
    pulses = 0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clkk);
      if (stuck_release) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("t6_pulses", 32'(pulses), 32'd1);
    chk("t6_window", 32'(first >= 95 && first <= 110), 32'd1);
    chk("t6_keys", 32'(keys_down), 32'd0);
    chk("t6_rowbits", 32'(rowbits), 32'h00);
    chk("t6_mods_kept", 32'(mods), 32'h01);
    // reset in the middle of a pause sequence
    send(8'hE0); send(8'hF0); send(8'hE1); send(8'h14);
    @(negedge clkk) reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst2_ready", 32'(byte_ready), 32'd1);
    send(8'h1C);
    idle(4);
    chk("rst2_code", 32'(last_code), 32'h01C);
    chk("rst2_make", 32'(last_make), 32'd1);
    chk("rst2_keys", 32'(keys_down), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_matrix_engine.md
Name: ps2_matrix_engine

Overview:
- Parametrised successor to the fixed 8x8 Vector keyboard matrix model.
- Consumes a PS/2 scancode byte stream over a valid/ready handshake and decodes the E0, F0 and E1 prefixes.
- Resolves each code through an external clocked mapper, then maintains a ROWS x COLS key matrix plus MOD_N modifier flags.
- Adds a per-key event output, a pressed-key counter, a bulk release input (OSD/focus loss) and a stuck-key watchdog.

Parameters:
ROWS, 8, matrix rows (1..16)
COLS, 8, matrix columns (1..16)
MOD_N, 8, number of modifier flags (shift, ctrl, rus, blk*, etc.)
MAP_LAT, 1, mapper latency in cycles (1..3)
STUCK_TIMEOUT, 24'd0, idle cycles before forced release; 0 disables the watchdog
E1_SKIP, 7, bytes discarded after an E1 (Pause) prefix

Ports:
clkk  in  1  clock
reset  in  1  synchronous, active-high
byte_valid  in  1  scancode byte available
byte_data  in  8  scancode byte
byte_ready  out  1  byte accepted when byte_valid&byte_ready
map_code  out  9  {ext, code} presented to the mapper
map_kind  in  2  0 = unmapped, 1 = matrix key, 2 = modifier
map_row  in  clog2(ROWS)  row index
map_col  in  clog2(COLS)  column index
map_mod  in  clog2(MOD_N)  modifier index
rowselect  in  ROWS  active-high row select
rowbits  out  COLS  OR of the selected rows, registered
mods  out  MOD_N  modifier flags
all_release  in  1  clear matrix and modifiers
event_valid  out  1  one-cycle pulse per applied make/break
event_make  out  1  1 = make, 0 = break
event_code  out  9  {ext, code} of the event
keys_down  out  clog2(ROWS*COLS+1)  number of set matrix bits
stuck_release  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset: reset is synchronous and active-high; clock is clkk.
  - Matrix, mods, rowbits, keys_down, event_*, stuck_release, ext/brk flags and the watchdog counter are all 0.
  - State = IDLE, byte_ready = 1.
- IDLE (byte_ready = 1), on an accepted byte:
  - E0: set ext, stay in IDLE.
  - F0: set brk, stay in IDLE.
  - E1: load skip counter with E1_SKIP, go to SKIP.
  - Any other byte: latch it into map_code with the current ext, go to LOOKUP.
- SKIP (byte_ready = 1): each accepted byte decrements the counter; at 0 return to IDLE with ext/brk cleared. No events are produced.
- LOOKUP (byte_ready = 0): map_code is held stable; wait MAP_LAT cycles, then sample map_* and go to APPLY.
- APPLY (byte_ready = 0), one cycle, then IDLE with ext/brk cleared:
  - kind 1, make: set bit [row][col].
  - kind 1, break: clear bit [row][col].
  - kind 2: mods[idx] = !brk.
  - kind 0: no state change and no event.
  - event_valid pulses for kind 1/2 in the cycle after APPLY.
- Latency: byte accepted in cycle N → matrix updated at end of N+1+MAP_LAT → rowbits reflects it one cycle later.
- keys_down increments only on a 0→1 transition and decrements only on a 1→0 transition. Therefore:
  - Typematic repeat of a held key: matrix and count unchanged, but event_valid still pulses with make = 1.
  - Break of a key that is not pressed: ignored, but the event still pulses.
- row/col indices ≥ ROWS/COLS are treated as kind 0.
- all_release: in the following cycle, matrix, mods and keys_down are 0.
  - Parser state is not touched; an in-flight lookup still completes.
  - If all_release coincides with APPLY, all_release wins and the applied update is discarded.
- Watchdog: the counter resets on every accepted byte and whenever keys_down = 0. When it reaches STUCK_TIMEOUT:
  - clear the matrix (mods are kept);
  - pulse stuck_release once;
  - restart the counter.
- rowbits = OR over the selected rows, registered; if rowselect = 0, rowbits = 0.
- Reset asserted mid-sequence (including SKIP or LOOKUP): abandon the sequence immediately; the next byte is parsed fresh.

Decomposition:
- Package ps2_matrix_pkg:
  - prefix constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, PS2_PAUSE = 8'hE1;
  - map_kind encodings MAP_NONE, MAP_KEY, MAP_MOD;
  - parser state enum.
- Sub-module ps2_prefix_parser: owns IDLE/SKIP/LOOKUP/APPLY, the ext/brk flags and byte_ready.
- The top level holds the matrix, modifiers, counter, watchdog and row OR.

Test Plan:
1. Bytes 1C, then F0 1C; mapper returns 1C → kind 1 (2,3). Expected: bit [2][3] = 1 and keys_down = 1; rowselect = 8'h04 → rowbits = 8'h08; after the break, rowbits = 0 and keys_down = 0.
2. Bytes E0 75; mapper returns {1,75} → kind 1 (7,0). Expected: map_code = 9'h175, event_code = 9'h175, make = 1. Follow with F0 75 (mapper {0,75} → kind 0): no event, and the matrix is unchanged.
3. Bytes 12, then F0 12; mapper returns kind 2, idx 0. Expected: mods[0] = 1, then 0, each with one event pulse; keys_down stays 0.
4. Bytes E1 14 77 E1 F0 14 F0 77, then 1C. Expected: no events for the first 8 bytes; 1C is parsed normally.
5. Make 1C, repeat 1C three times, then all_release in the same cycle as the third APPLY. Expected: keys_down = 1 after the repeats, 0 after all_release; four event pulses in total.
6. STUCK_TIMEOUT = 100, make 1C, then no further bytes. Expected: stuck_release pulses at cycle 100 after acceptance; matrix cleared; mods unchanged.
